// File: rtl/dmem_write_buffer_pkg.sv
// Shared constants for the data-memory write buffer: result-detector addresses and data.
// No latency or backpressure of its own; imported by the buffer RTL.
// Holds only constants.
package dmem_write_buffer_pkg;

    localparam logic [31:0] DONE_ADDR    = 32'd100;
    localparam logic [31:0] DONE_DATA    = 32'd7;
    localparam logic [31:0] SCRATCH_ADDR = 32'd96;

endpackage

// File: rtl/dmem_write_buffer_if.sv
// Core-side store/load bus of the data-memory write buffer.
// Latency: none (wires only). Backpressure: Stall from slave tells master to hold its store.
// master = core/testbench, slave = dmem_write_buffer.
interface dmem_write_buffer_if;

    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        DrainEn;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Empty;
    logic        Done;
    logic        Pass;

    modport master (
        output MemWrite, DataAdr, WriteData, DrainEn,
        input  ReadData, Stall, Empty, Done, Pass
    );

    modport slave (
        input  MemWrite, DataAdr, WriteData, DrainEn,
        output ReadData, Stall, Empty, Done, Pass
    );

endinterface

// File: rtl/dmem_write_buffer_wbuf_fifo.sv
// Circular store buffer {word index, data} with a parallel youngest-hit match port.
// Latency: push visible to match/pop one cycle after acceptance; match is combinational.
// Backpressure: push ignored while full; pop ignored while empty.
module wbuf_fifo #(
    parameter int DEPTH = 4,
    parameter int IW    = 6
) (
    input  logic          clk,
    input  logic          Reset,
    input  logic          push,
    input  logic [IW-1:0] push_idx,
    input  logic [31:0]   push_dat,
    input  logic          pop,
    output logic [IW-1:0] pop_idx,
    output logic [31:0]   pop_dat,
    output logic          full,
    output logic          empty,
    input  logic [IW-1:0] match_idx,
    output logic          match_hit,
    output logic [31:0]   match_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [IW-1:0] idx_q [DEPTH];
    logic [31:0]   dat_q [DEPTH];
    logic [AW-1:0] head, tail;
    logic [AW:0]   count;
    logic          do_push, do_pop;
    logic [AW-1:0] pos;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_idx = idx_q[head];
    assign pop_dat = dat_q[head];

    always_ff @(posedge clk) begin
        if (Reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_ONE;
            if (do_pop)  head <= head + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            idx_q[tail] <= push_idx;
            dat_q[tail] <= push_dat;
        end
    end

    // Walk oldest to youngest so the last valid hit (youngest store) wins.
    always_comb begin
        match_hit = 1'b0;
        match_dat = '0;
        pos       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = head + AW'(k);
            if ((k < int'(count)) && (idx_q[pos] == match_idx)) begin
                match_hit = 1'b1;
                match_dat = dat_q[pos];
            end
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// Data memory with a store write buffer drained into word RAM; loads forward from buffered stores.
// Latency: load combinational; store visible next cycle, reaches RAM on a DrainEn cycle in order.
// Backpressure: Stall while buffer full. Optional result detector under DMEM_DONE_DETECT_EN.
module dmem_write_buffer
    import dmem_write_buffer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MEM_WORDS = 64
) (
    input  logic                clk,
    input  logic                Reset,
    dmem_write_buffer_if.slave  bus
);

    localparam int IW = $clog2(MEM_WORDS);

    logic [31:0]   ram [MEM_WORDS];
    logic [IW-1:0] idx;
    logic [IW-1:0] pop_idx;
    logic [31:0]   pop_dat;
    logic          stall, empty, hit, drain;
    logic [31:0]   hit_dat;
    logic          unused_adr_bits;

    // Byte-offset bits are ignored and high bits alias onto the RAM.
    assign idx             = bus.DataAdr[IW+1:2];
    assign unused_adr_bits = ^{bus.DataAdr[31:IW+2], bus.DataAdr[1:0]};

    wbuf_fifo #(.DEPTH(DEPTH), .IW(IW)) u_wbuf (
        .clk       (clk),
        .Reset     (Reset),
        .push      (bus.MemWrite),
        .push_idx  (idx),
        .push_dat  (bus.WriteData),
        .pop       (bus.DrainEn),
        .pop_idx   (pop_idx),
        .pop_dat   (pop_dat),
        .full      (stall),
        .empty     (empty),
        .match_idx (idx),
        .match_hit (hit),
        .match_dat (hit_dat)
    );

    assign drain     = bus.DrainEn && !empty;
    assign bus.Stall = stall;
    assign bus.Empty = empty;
    assign bus.ReadData = hit ? hit_dat : ram[idx];

    // RAM itself is never cleared; Reset only suppresses an in-flight drain.
    always_ff @(posedge clk) begin
        if (!Reset && drain) ram[pop_idx] <= pop_dat;
    end

`ifdef DMEM_DONE_DETECT_EN
    logic done_q, pass_q;
    logic accepted;

    assign accepted = bus.MemWrite && !stall;

    always_ff @(posedge clk) begin
        if (Reset) begin
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else if (accepted && !done_q) begin
            if (bus.DataAdr == DONE_ADDR) begin
                done_q <= 1'b1;
                pass_q <= (bus.WriteData == DONE_DATA);
            end else if (bus.DataAdr != SCRATCH_ADDR) begin
                done_q <= 1'b1;
                pass_q <= 1'b0;
            end
        end
    end

    assign bus.Done = done_q;
    assign bus.Pass = pass_q;
`else
    assign bus.Done = 1'b0;
    assign bus.Pass = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer with a queue-based reference model and load scoreboard.
module tb_dmem_write_buffer;

    localparam int DEPTH     = 4;
    localparam int MEM_WORDS = 64;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] dat;
    } ent_t;

    logic clk = 1'b0;
    logic Reset;
    dmem_write_buffer_if bus();

    dmem_write_buffer #(.DEPTH(DEPTH), .MEM_WORDS(MEM_WORDS)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mram [MEM_WORDS];
    ent_t        mq[$];
    logic [31:0] exp_q[$];
    logic        mdone, mpass;
    int          n_chk  = 0;
    int          n_fail = 0;

    function automatic logic [31:0] model_read(input logic [31:0] adr);
        logic [5:0]  ix;
        logic [31:0] r;
        ix = adr[7:2];
        r  = mram[ix];
        for (int k = 0; k < mq.size(); k++)
            if (mq[k].idx == ix) r = mq[k].dat;
        return r;
    endfunction

    task automatic model_step(input logic mw, input logic [31:0] adr,
                              input logic [31:0] wd, input logic de);
        int   n;
        ent_t e;
        n = mq.size();
        if (de && n > 0) begin
            mram[mq[0].idx] = mq[0].dat;
            void'(mq.pop_front());
        end
        if (mw && n < DEPTH) begin
            e.idx = adr[7:2];
            e.dat = wd;
            mq.push_back(e);
`ifdef DMEM_DONE_DETECT_EN
            if (!mdone) begin
                if (adr == 32'd100) begin
                    mdone = 1'b1;
                    mpass = (wd == 32'd7);
                end else if (adr != 32'd96) begin
                    mdone = 1'b1;
                    mpass = 1'b0;
                end
            end
`endif
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic mw, input logic [31:0] adr,
                       input logic [31:0] wd, input logic de);
        @(negedge clk);
        bus.MemWrite  = mw;
        bus.DataAdr   = adr;
        bus.WriteData = wd;
        bus.DrainEn   = de;
        @(posedge clk);
        model_step(mw, adr, wd, de);
        #1;
        bus.MemWrite = 1'b0;
        bus.DrainEn  = 1'b0;
    endtask

    task automatic do_reset(input logic de);
        @(negedge clk);
        Reset        = 1'b1;
        bus.MemWrite = 1'b0;
        bus.DrainEn  = de;
        @(posedge clk);
        mq.delete();
        mdone = 1'b0;
        mpass = 1'b0;
        #1;
        Reset       = 1'b0;
        bus.DrainEn = 1'b0;
    endtask

    task automatic chk_load(input string tag, input logic [31:0] adr);
        bus.DataAdr = adr;
        exp_q.push_back(model_read(adr));
        #1;
        chk(tag, bus.ReadData, exp_q.pop_front());
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_stall"}, 32'(bus.Stall), 32'(mq.size() == DEPTH));
        chk({tag, "_empty"}, 32'(bus.Empty), 32'(mq.size() == 0));
        chk({tag, "_done"},  32'(bus.Done),  32'(mdone));
        chk({tag, "_pass"},  32'(bus.Pass),  32'(mpass));
    endtask

    initial begin
        Reset         = 1'b1;
        bus.MemWrite  = 1'b0;
        bus.DataAdr   = '0;
        bus.WriteData = '0;
        bus.DrainEn   = 1'b0;
        mdone         = 1'b0;
        mpass         = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) mram[i] = '0;
        do_reset(1'b0);
        do_reset(1'b0);
        chk("rst_stall", 32'(bus.Stall), 32'd0);
        chk("rst_empty", 32'(bus.Empty), 32'd1);
        chk("rst_done",  32'(bus.Done),  32'd0);
        chk("rst_pass",  32'(bus.Pass),  32'd0);

        // Preload every RAM word with a known pattern through the buffer.
        for (int i = 0; i < MEM_WORDS; i++)
            cyc(1'b1, 32'(i * 4), 32'h1000_0000 ^ 32'(i * 32'h0101), 1'b1);
        cyc(1'b0, 32'd0, 32'd0, 1'b1);
        chk_flags("pre");
        chk_load("pre_ld0", 32'd0);
        chk_load("pre_ld63", 32'd252);
        do_reset(1'b0);

        // 1: forwarding of a buffered store
        cyc(1'b1, 32'd8, 32'h0000_00AA, 1'b0);
        chk_flags("t1");
        chk_load("t1_fwd8", 32'd8);
        chk_load("t1_ld9_offset", 32'd9);
        chk_load("t1_ld12", 32'd12);
        cyc(1'b0, 32'd0, 32'd0, 1'b1);
        chk_flags("t1_drained");
        chk_load("t1_ram8", 32'd8);

        // 2: fill, ignored 5th store, ordered drain
        cyc(1'b1, 32'd0,  32'hA0, 1'b0);
        cyc(1'b1, 32'd4,  32'hA1, 1'b0);
        cyc(1'b1, 32'd8,  32'hA2, 1'b0);
        cyc(1'b1, 32'd12, 32'hA3, 1'b0);
        chk_flags("t2_full");
        cyc(1'b1, 32'd16, 32'hA4, 1'b0);
        chk_flags("t2_5th");
        chk_load("t2_ld16", 32'd16);
        chk_load("t2_ld4", 32'd4);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 32'd0, 32'd0, 1'b1);
            chk_load("t2_drain_ld0", 32'd0);
            chk_load("t2_drain_ld12", 32'd12);
        end
        chk_flags("t2_empty");
        chk_load("t2_ram16", 32'd16);

        // 3: repeated store to one word, plus an aliased address
        cyc(1'b1, 32'd20, 32'h1, 1'b0);
        cyc(1'b1, 32'd20, 32'h2, 1'b0);
        chk_load("t3_fwd_youngest", 32'd20);
        cyc(1'b1, 32'd276, 32'h3, 1'b0);
        chk_load("t3_alias", 32'd20);
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1);
        chk_flags("t3_empty");
        chk_load("t3_ram5", 32'd20);

        // 4: drain while full blocks enqueue; then store+drain holds count
        cyc(1'b1, 32'd24, 32'hB0, 1'b0);
        cyc(1'b1, 32'd28, 32'hB1, 1'b0);
        cyc(1'b1, 32'd32, 32'hB2, 1'b0);
        cyc(1'b1, 32'd36, 32'hB3, 1'b0);
        cyc(1'b1, 32'd40, 32'hB4, 1'b1);
        chk_flags("t4_full_drain");
        chk_load("t4_ld40", 32'd40);
        cyc(1'b1, 32'd44, 32'hB5, 1'b1);
        chk_flags("t4_both");
        cyc(1'b1, 32'd48, 32'hB6, 1'b0);
        chk_flags("t4_refill");
        chk_load("t4_ld44", 32'd44);
        for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 32'd0, 1'b1);
        chk_load("t4_ram24", 32'd24);
        chk_load("t4_ram48", 32'd48);

        // 5: reset discards pending entries and suppresses the drain
        cyc(1'b1, 32'd52, 32'hC0, 1'b0);
        cyc(1'b1, 32'd56, 32'hC1, 1'b0);
        cyc(1'b1, 32'd60, 32'hC2, 1'b0);
        do_reset(1'b1);
        chk_flags("t5");
        chk_load("t5_ld52", 32'd52);
        chk_load("t5_ld60", 32'd60);

        // 6: result detector (tied low when not built in)
        cyc(1'b1, 32'd96, 32'h55, 1'b1);
        chk_flags("t6_scratch");
        cyc(1'b1, 32'd100, 32'd7, 1'b1);
        chk_flags("t6_pass");
        cyc(1'b1, 32'd104, 32'd9, 1'b1);
        chk_flags("t6_hold");
        do_reset(1'b0);
        cyc(1'b1, 32'd104, 32'd3, 1'b1);
        chk_flags("t6_other");
        do_reset(1'b0);
        cyc(1'b1, 32'd100, 32'd8, 1'b1);
        chk_flags("t6_baddata");
        cyc(1'b0, 32'd0, 32'd0, 1'b1);
        chk_load("t6_ram25", 32'd100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
